wb_arbiter: RTL and testbench

- Shares the single register-file write port between the ALU write-back path and the LSU load-return path.
- Uses a round-robin arbiter with valid/ready handshakes and a registered write port.
- Keeps a per-register pending scoreboard so the decode stage stalls on any instruction whose source or destination register has an outstanding write.
- Sits between the execute/LSU stages and the general register file x[0:31].

---
 rtl/wb_pkg.sv | 7 +
 rtl/rr_arb2.sv | 24 ++
 rtl/wb_arbiter.sv | 86 ++++++++
 tb/tb_wb_arbiter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and grant encoding for the write-back arbiter.
package wb_pkg;
  localparam int REG_IDX_W = 5;
  localparam int XLEN = 32;
  localparam logic GNT_ALU = 1'b0;
  localparam logic GNT_LSU = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester arbiter, round-robin or fixed LSU priority, remembering the last winner.
module rr_arb2
  import wb_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_alu_i,
  input  logic       req_lsu_i,
  output logic [1:0] gnt_o,
  output logic       any_o
);
  logic last_q;
  always_comb begin
    gnt_o[GNT_LSU] = (req_alu_i & req_lsu_i) ? ((RR_EN != 0) ? (last_q == GNT_ALU) : 1'b1) : req_lsu_i;
    gnt_o[GNT_ALU] = req_alu_i & ~gnt_o[GNT_LSU];
    any_o = req_alu_i | req_lsu_i;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= GNT_LSU;
    else if (any_o) last_q <= gnt_o[GNT_LSU] ? GNT_LSU : GNT_ALU;
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the register-file write port between ALU and LSU write-back,
// and tracks outstanding writes so decode can stall on RAW/WAW hazards.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN_P = XLEN,
  parameter int NREG = 32,
  parameter int RR_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_wb_valid_i,
  input  logic [REG_IDX_W-1:0] alu_wb_rd_i,
  input  logic [XLEN_P-1:0]    alu_wb_data_i,
  output logic                 alu_wb_ready_o,
  input  logic                 lsu_wb_valid_i,
  input  logic [REG_IDX_W-1:0] lsu_wb_rd_i,
  input  logic [XLEN_P-1:0]    lsu_wb_data_i,
  output logic                 lsu_wb_ready_o,
  output logic                 rf_we_o,
  output logic [REG_IDX_W-1:0] rf_waddr_o,
  output logic [XLEN_P-1:0]    rf_wdata_o,
  input  logic                 issue_valid_i,
  input  logic [REG_IDX_W-1:0] issue_rd_i,
  input  logic [REG_IDX_W-1:0] issue_rs1_i,
  input  logic [REG_IDX_W-1:0] issue_rs2_i,
  output logic                 hazard_o,
  input  logic                 flush_i,
  output logic [15:0]          conflict_cnt_o
);
  logic [1:0] gnt;
  logic any_gnt;
  logic [REG_IDX_W-1:0] g_rd;
  logic [XLEN_P-1:0] g_data;
  logic [NREG-1:0] pend_q, pend_d, set_m, clr_m, upd;
  logic [15:0] cnt_q;
  logic we_q;
  logic [REG_IDX_W-1:0] waddr_q;
  logic [XLEN_P-1:0] wdata_q;

  rr_arb2 #(.RR_EN(RR_EN)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_alu_i(alu_wb_valid_i),
    .req_lsu_i(lsu_wb_valid_i),
    .gnt_o    (gnt),
    .any_o    (any_gnt)
  );

  assign alu_wb_ready_o = gnt[GNT_ALU];
  assign lsu_wb_ready_o = gnt[GNT_LSU];

  // Set is applied after clear so a same-register set/clear on one edge leaves it pending.
  always_comb begin
    g_rd = gnt[GNT_LSU] ? lsu_wb_rd_i : alu_wb_rd_i;
    g_data = gnt[GNT_LSU] ? lsu_wb_data_i : alu_wb_data_i;
    hazard_o = issue_valid_i & (pend_q[issue_rs1_i] | pend_q[issue_rs2_i] | pend_q[issue_rd_i]);
    set_m = (issue_valid_i & ~hazard_o & (|issue_rd_i)) ? (NREG'(1) << issue_rd_i) : '0;
    clr_m = any_gnt ? (NREG'(1) << g_rd) : '0;
    upd = (pend_q & ~clr_m) | set_m;
    pend_d = flush_i ? '0 : {upd[NREG-1:1], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      pend_q <= '0;
      cnt_q <= '0;
    end else begin
      we_q <= any_gnt & (|g_rd);
      if (any_gnt) begin
        waddr_q <= g_rd;
        wdata_q <= g_data;
      end
      pend_q <= pend_d;
      if (alu_wb_valid_i & lsu_wb_valid_i & ~(&cnt_q)) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign rf_we_o = we_q;
  assign rf_waddr_o = waddr_q;
  assign rf_wdata_o = wdata_q;
  assign conflict_cnt_o = cnt_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and randomized checks of wb_arbiter against a behavioural model.
module tb_wb_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic alu_v = 1'b0, lsu_v = 1'b0, iss_v = 1'b0, flush = 1'b0;
  logic [4:0] alu_rd = '0, lsu_rd = '0, iss_rd = '0, iss_rs1 = '0, iss_rs2 = '0;
  logic [31:0] alu_d = '0, lsu_d = '0;
  logic alu_rdy, lsu_rdy, rf_we, hazard;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata;
  logic [15:0] cnt;

  int tests = 0, fails = 0;
  bit [31:0] m_pend = '0;
  bit m_last_lsu = 1'b1, m_we = 1'b0;
  bit [4:0] m_waddr = '0;
  bit [31:0] m_wdata = '0;
  int m_cnt = 0;
  bit e_ag = 1'b0, e_lg = 1'b0;

  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_wb_valid_i(alu_v), .alu_wb_rd_i(alu_rd), .alu_wb_data_i(alu_d), .alu_wb_ready_o(alu_rdy),
    .lsu_wb_valid_i(lsu_v), .lsu_wb_rd_i(lsu_rd), .lsu_wb_data_i(lsu_d), .lsu_wb_ready_o(lsu_rdy),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .issue_valid_i(iss_v), .issue_rd_i(iss_rd), .issue_rs1_i(iss_rs1), .issue_rs2_i(iss_rs2),
    .hazard_o(hazard), .flush_i(flush), .conflict_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_last_lsu = 1'b1; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_cnt = 0;
  endtask

  // One cycle: drive at posedge+1, check combinational outputs, then registered outputs after the edge.
  task automatic step(input bit av, input bit [4:0] ard, input bit [31:0] ad,
                      input bit lv, input bit [4:0] lrd, input bit [31:0] ld,
                      input bit iv, input bit [4:0] ird, input bit [4:0] irs1, input bit [4:0] irs2,
                      input bit fl);
    bit haz;
    bit [4:0] grd;
    alu_v = av; alu_rd = ard; alu_d = ad;
    lsu_v = lv; lsu_rd = lrd; lsu_d = ld;
    iss_v = iv; iss_rd = ird; iss_rs1 = irs1; iss_rs2 = irs2; flush = fl;
    #1;
    if (av && lv) begin
      e_lg = !m_last_lsu;
      e_ag = m_last_lsu;
    end else begin
      e_ag = av;
      e_lg = lv;
    end
    haz = iv && (m_pend[irs1] || m_pend[irs2] || m_pend[ird]);
    chk("alu_ready", {31'd0, alu_rdy}, {31'd0, e_ag});
    chk("lsu_ready", {31'd0, lsu_rdy}, {31'd0, e_lg});
    chk("hazard", {31'd0, hazard}, {31'd0, haz});
    grd = e_lg ? lrd : ard;
    if (e_ag || e_lg) begin
      m_we = (grd != 0);
      m_waddr = grd;
      m_wdata = e_lg ? ld : ad;
      m_last_lsu = e_lg;
    end else m_we = 1'b0;
    if (av && lv && m_cnt < 65535) m_cnt++;
    if (fl) m_pend = '0;
    else begin
      if (e_ag || e_lg) m_pend[grd] = 1'b0;
      if (iv && !haz && ird != 0) m_pend[ird] = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("rf_we", {31'd0, rf_we}, {31'd0, m_we});
    chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_waddr});
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("conflict_cnt", {16'd0, cnt}, m_cnt);
  endtask

  initial begin
    bit a_v, l_v;
    bit [4:0] a_rd, l_rd;
    bit [31:0] a_d, l_d;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_we", {31'd0, rf_we}, 32'd0);
    chk("reset_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("reset_wdata", rf_wdata, 32'd0);
    chk("reset_cnt", {16'd0, cnt}, 32'd0);
    // Simultaneous requests straight after reset: ALU wins first.
    step(1, 3, 32'h33, 1, 4, 32'h44, 0, 0, 0, 0, 0);
    chk("both_first_alu", {31'd0, e_ag}, 32'd1);
    step(0, 3, 32'h33, 1, 4, 32'h44, 0, 0, 0, 0, 0);
    chk("both_cnt", {16'd0, cnt}, 32'd1);
    // Single ALU write.
    step(1, 5, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("alu_write_data", rf_wdata, 32'h1234_5678);
    // RAW on x7 resolved by an LSU write-back.
    step(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0);
    step(0, 0, 0, 1, 7, 32'hCAFE, 1, 1, 7, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0);
    // x0 never becomes pending and never writes.
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    step(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("x0_no_we", {31'd0, rf_we}, 32'd0);
    // Flush with a concurrent LSU write-back.
    step(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 10, 0, 0, 0);
    step(0, 0, 0, 1, 9, 32'h99, 1, 11, 0, 0, 1);
    chk("flush_we", {31'd0, rf_we}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 1, 11, 9, 10, 0);
    // Randomized traffic; a losing requester holds its request until granted.
    a_v = 0; l_v = 0; a_rd = 0; l_rd = 0; a_d = 0; l_d = 0;
    for (int i = 0; i < 400; i++) begin
      if (!(a_v && !e_ag)) begin a_v = 1'($urandom); a_rd = 5'($urandom); a_d = $urandom; end
      if (!(l_v && !e_lg)) begin l_v = 1'($urandom); l_rd = 5'($urandom); l_d = $urandom; end
      step(a_v, a_rd, a_d, l_v, l_rd, l_d, 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           $urandom_range(0, 15) == 0);
    end
    // Async reset while a write is being presented.
    step(0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0);
    step(1, 5, 32'hA5A5, 1, 6, 32'h5A5A, 0, 0, 0, 0, 0);
    chk("pre_reset_we", {31'd0, rf_we}, 32'd1);
    alu_v = 0; lsu_v = 0; iss_v = 0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async_we", {31'd0, rf_we}, 32'd0);
    chk("async_wdata", rf_wdata, 32'd0);
    chk("async_cnt", {16'd0, cnt}, 32'd0);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, 0, 1, 12, 12, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
